// File: rtl/vga_sync_decoder_pkg.sv
`default_nettype none
// ============================================================
// Package : vga_sync_decoder_pkg
// Brief   : VGA timing defaults and lock-FSM encoding shared with the controller.
// Revision: 1.0
// ============================================================
package vga_sync_decoder_pkg;

   localparam int C_CNT_W = 10;
   localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;

   localparam int C_H_TOTAL     = 800;
   localparam int C_H_SYNC      = 96;
   localparam int C_H_ACT_START = 144;
   localparam int C_H_ACT_END   = 784;
   localparam int C_V_TOTAL     = 521;
   localparam int C_V_SYNC      = 2;
   localparam int C_V_ACT_START = 31;
   localparam int C_V_ACT_END   = 511;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } sync_state_t;

   function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
      return (v == C_CNT_MAX) ? v : v + C_CNT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_decoder_sync_edge_counter.sv
`default_nettype none
// ============================================================
// Module  : sync_edge_counter
// Brief   : Sync edge detect, position counter and period/width check for one axis.
// Revision: 1.0
// ============================================================
module sync_edge_counter
   import vga_sync_decoder_pkg::*;
#(
   parameter int PERIOD = C_H_TOTAL,
   parameter int WIDTH  = C_H_SYNC
) (
   input  logic               dclk,
   input  logic               clr_n,
   input  logic               i_sync,
   input  logic               i_en,
   output logic               o_fall,
   output logic [C_CNT_W-1:0] o_cnt,
   output logic               o_err
);

   localparam logic [C_CNT_W-1:0] C_FALL_AT = C_CNT_W'(PERIOD - 1);
   localparam logic [C_CNT_W-1:0] C_RISE_AT = C_CNT_W'(WIDTH - 1);

   logic               r_sync_d;
   logic [C_CNT_W-1:0] r_cnt;
   logic               w_rise;

   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         r_sync_d <= 1'b1;
         r_cnt    <= '0;
      end else begin
         r_sync_d <= i_sync;
         if (i_en) begin
            r_cnt <= o_fall ? '0 : sat_inc(r_cnt);
         end
      end
   end

   assign o_fall = r_sync_d & ~i_sync;
   assign w_rise = ~r_sync_d & i_sync;
   assign o_cnt  = r_cnt;

   // The rising edge is only legal on a counting step that lands exactly on the pulse width.
   assign o_err = (o_fall && (r_cnt != C_FALL_AT))
               || (w_rise && !(i_en && (r_cnt == C_RISE_AT)))
               || (r_cnt == C_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================
// Module  : vga_sync_decoder
// Brief   : Locks onto an incoming VGA sync stream and recovers pixel coordinates.
// Revision: 1.0
// ============================================================
module vga_sync_decoder
   import vga_sync_decoder_pkg::*;
#(
   parameter int H_TOTAL     = C_H_TOTAL,
   parameter int H_SYNC      = C_H_SYNC,
   parameter int H_ACT_START = C_H_ACT_START,
   parameter int H_ACT_END   = C_H_ACT_END,
   parameter int V_TOTAL     = C_V_TOTAL,
   parameter int V_SYNC      = C_V_SYNC,
   parameter int V_ACT_START = C_V_ACT_START,
   parameter int V_ACT_END   = C_V_ACT_END
) (
   input  logic         dclk,
   input  logic         clr_n,
   input  logic         hsync,
   input  logic         vsync,
   input  logic [2:0]   red,
   input  logic [2:0]   green,
   input  logic [1:0]   blue,
   output logic [9:0]   x,
   output logic [9:0]   y,
   output logic [7:0]   pixel,
   output logic         de,
   output logic         frame_start,
   output logic         locked,
   output logic         err_h,
   output logic         err_v,
   output logic [7:0]   frame_count
);

   localparam logic [C_CNT_W-1:0] C_HA_LO = C_CNT_W'(H_ACT_START);
   localparam logic [C_CNT_W-1:0] C_HA_HI = C_CNT_W'(H_ACT_END);
   localparam logic [C_CNT_W-1:0] C_VA_LO = C_CNT_W'(V_ACT_START);
   localparam logic [C_CNT_W-1:0] C_VA_HI = C_CNT_W'(V_ACT_END);

   logic               w_hfall, w_vfall;
   logic               w_herr_raw, w_verr_raw;
   logic [C_CNT_W-1:0] w_hcnt, w_vcnt;

   sync_edge_counter #(
      .PERIOD (H_TOTAL),
      .WIDTH  (H_SYNC)
   ) u_h_axis (
      .dclk   (dclk),
      .clr_n  (clr_n),
      .i_sync (hsync),
      .i_en   (1'b1),
      .o_fall (w_hfall),
      .o_cnt  (w_hcnt),
      .o_err  (w_herr_raw)
   );

   sync_edge_counter #(
      .PERIOD (V_TOTAL),
      .WIDTH  (V_SYNC)
   ) u_v_axis (
      .dclk   (dclk),
      .clr_n  (clr_n),
      .i_sync (vsync),
      .i_en   (w_hfall),
      .o_fall (w_vfall),
      .o_cnt  (w_vcnt),
      .o_err  (w_verr_raw)
   );

   // Checks stay muted until the first vsync fall after reset has realigned both counters.
   logic r_armed;
   logic w_line_err, w_frame_err, w_any_err;

   assign w_line_err  = r_armed & w_herr_raw;
   assign w_frame_err = r_armed & w_verr_raw;
   assign w_any_err   = w_line_err | w_frame_err;

   sync_state_t r_state, w_state_nxt;

   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= ST_SEARCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_SEARCH: if (w_vfall) w_state_nxt = ST_ALIGN;
         ST_ALIGN: begin
            if (w_any_err)    w_state_nxt = ST_SEARCH;
            else if (w_vfall) w_state_nxt = ST_VERIFY;
         end
         ST_VERIFY: begin
            if (w_any_err)    w_state_nxt = ST_SEARCH;
            else if (w_vfall) w_state_nxt = ST_LOCKED;
         end
         ST_LOCKED: if (w_any_err) w_state_nxt = ST_SEARCH;
         default:   w_state_nxt = ST_SEARCH;
      endcase
   end

   logic w_in_act, w_de_nxt, w_fs_nxt;

   assign w_in_act = (w_hcnt >= C_HA_LO) && (w_hcnt < C_HA_HI)
                  && (w_vcnt >= C_VA_LO) && (w_vcnt < C_VA_HI);
   assign w_de_nxt = (r_state == ST_LOCKED) && w_in_act;
   assign w_fs_nxt = (r_state == ST_LOCKED) && w_vfall && !w_any_err;

   logic [9:0] r_x, r_y;
   logic [7:0] r_pixel, r_frame_count;
   logic       r_de, r_frame_start, r_err_h, r_err_v;

   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         r_armed       <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_pixel       <= '0;
         r_de          <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
         r_err_h       <= 1'b0;
         r_err_v       <= 1'b0;
      end else begin
         if (w_vfall) r_armed <= 1'b1;
         r_de          <= w_de_nxt;
         r_x           <= w_de_nxt ? (w_hcnt - C_HA_LO) : '0;
         r_y           <= w_de_nxt ? (w_vcnt - C_VA_LO) : '0;
         r_pixel       <= w_de_nxt ? {red, green, blue} : '0;
         r_frame_start <= w_fs_nxt;
         if (w_fs_nxt)    r_frame_count <= r_frame_count + 8'd1;
         if (w_line_err)  r_err_h <= 1'b1;
         if (w_frame_err) r_err_v <= 1'b1;
      end
   end

   assign x           = r_x;
   assign y           = r_y;
   assign pixel       = r_pixel;
   assign de          = r_de;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;
   assign err_h       = r_err_h;
   assign err_v       = r_err_v;
   assign locked      = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_TOTAL, default 800, dclk cycles per line.
REQ-002 Parameter H_SYNC, default 96, hsync low width in dclk cycles.
REQ-003 Parameter H_ACT_START / H_ACT_END, default 144 / 784, first active column / first column after active.
REQ-004 Parameter V_TOTAL, default 521, lines per frame.
REQ-005 Parameter V_SYNC, default 2, vsync low width in lines.
REQ-006 Parameter V_ACT_START / V_ACT_END, default 31 / 511, first active line / first line after active.
REQ-007 dclk  in  1  pixel clock; the only clock; all logic on its rising edge.
REQ-008 clr_n  in  1  asynchronous, active-low reset.
REQ-009 hsync / vsync  in  1 each  active-low sync from the VGA controller, synchronous to dclk.
REQ-010 red  in  3, green  in  3, blue  in  2  pixel colour.
REQ-011 x / y  out  10 each  active-area pixel coordinate, 0-based.
REQ-012 pixel  out  8  captured colour {red,green,blue}; de  out  1  coordinate/pixel valid.
REQ-013 frame_start  out  1  one-cycle pulse at the first hsync edge of each frame.
REQ-014 locked  out  1; err_h / err_v  out  1 each, sticky timing-error flags; frame_count  out  8.

Function
REQ-015 Edge detect: registered copy hs_d/vs_d; hsync falling edge = hs_d&!hsync; rising edge = !hs_d&hsync.
REQ-016 hcnt (10 bit) loads 0 on the cycle after a falling edge is sampled, else increments, saturating at 1023.
REQ-017 Line check: falling edge with hcnt != H_TOTAL-1 -> line error; rising edge with hcnt != H_SYNC-1 -> line error; hcnt reaching 1023 -> line error.
REQ-018 vcnt (10 bit) updates only on hsync falling edges: 0 if vsync sampled low and vs_d high at that edge, else +1, saturating at 1023.
REQ-019 Frame check at a vsync falling edge: vcnt != V_TOTAL-1 -> frame error; vsync rising edge must coincide with the hsync falling edge at which vcnt == V_SYNC-1, else frame error.
REQ-020 FSM states SEARCH, ALIGN, VERIFY, LOCKED.
REQ-021 SEARCH -> ALIGN on first vsync falling edge; ALIGN -> VERIFY at next vsync falling edge with no error during the frame; VERIFY -> LOCKED after a second error-free frame; any error in ALIGN/VERIFY -> SEARCH.
REQ-022 LOCKED: any line or frame error -> SEARCH same cycle; locked deasserts the following cycle.
REQ-023 Any line or frame error sets err_h or err_v respectively; flags clear only on reset.
REQ-024 de = locked && H_ACT_START <= hcnt < H_ACT_END && V_ACT_START <= vcnt < V_ACT_END.
REQ-025 x = hcnt-H_ACT_START, y = vcnt-V_ACT_START, pixel = colour inputs, all registered; latency one dclk from sampled inputs to outputs.
REQ-026 When de = 0: x, y, pixel hold 0.
REQ-027 frame_start pulses once per vsync falling edge while locked, coincident with y reset.
REQ-028 frame_count increments on each frame_start and wraps 255 -> 0.
REQ-029 Simultaneous hsync and vsync falling edges are the normal frame start, not an error.

Reset
REQ-030 While clr_n = 0: FSM = SEARCH; hcnt, vcnt, x, y, pixel, frame_count = 0; de, locked, frame_start, err_h, err_v = 0; hs_d, vs_d = 1.
REQ-031 Deassertion mid-frame: no error flagged before the first vsync falling edge after release.

Structure
REQ-032 Shared constants package holds the timing defaults and the FSM state encoding, shared with the VGA controller.
REQ-033 One sub-module, sync_edge_counter, instanced for the horizontal and vertical axes: edge detect, counter, width/period check.

Verification
REQ-034 Nominal 800x521 stream from reset -> locked rises at the 3rd vsync falling edge; err_h = err_v = 0.
REQ-035 Locked; colour 8'hE3 at hcnt 144, vcnt 31 -> one cycle later de = 1, x = 0, y = 0, pixel = 8'hE3.
REQ-036 Locked; one line 799 cycles long -> err_h = 1, locked = 0 next cycle; relock after two further clean frames.
REQ-037 Locked; vsync low for 3 lines -> err_v = 1, FSM = SEARCH.
REQ-038 256 clean locked frames -> frame_count wraps to 0; exactly one frame_start per frame.
REQ-039 clr_n pulsed low mid-frame -> all outputs 0 immediately; no error before the next vsync edge.
